// File: rtl/network_receive_port.sv
// TSN receive port: strips GMII preamble/SFD, packs frame bytes into PCB
// words under a pooled bufid, then emits a descriptor or returns the bufid.
module network_receive_port #(
   parameter int MAX_WORDS = 128,
   parameter int MIN_BYTES = 64
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [7:0]   iv_gmii_rxd,
   input  logic         i_gmii_rx_dv,
   input  logic         i_gmii_rx_er,
   input  logic [8:0]   iv_free_bufid,
   input  logic         i_bufid_empty,
   output logic         o_bufid_rd,
   output logic [133:0] ov_pkt_data,
   output logic [15:0]  ov_pkt_waddr,
   output logic         o_pkt_wr,
   output logic [59:0]  ov_descriptor,
   output logic         o_descriptor_wr,
   input  logic         i_descriptor_ack,
   output logic [8:0]   ov_release_bufid,
   output logic         o_release_wr,
   input  logic         i_release_ack,
   output logic         o_pkt_cnt_pulse,
   output logic         o_discard_pulse,
   output logic [2:0]   ov_nrp_state
);

   localparam logic [11:0] MAX_B = 12'(MAX_WORDS * 16);
   localparam logic [11:0] MIN_B = 12'(MIN_BYTES);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRE  = 3'd1,
      S_RECV = 3'd2,
      S_DESC = 3'd3,
      S_REL  = 3'd4,
      S_DROP = 3'd5
   } state_t;

   state_t         r_state;
   logic [127:0]   r_word;
   logic [3:0]     r_bidx;
   logic [6:0]     r_widx;
   logic [11:0]    r_cnt;
   logic [8:0]     r_bufid;
   logic [47:0]    r_tsn;
   logic           r_first;
   logic           r_bad;
   logic           r_late;

   logic           w_full_pend;
   logic           w_frame_bad;
   logic [3:0]     w_tail_vb;
   logic [6:0]     w_bpos;
   logic [11:0]    w_cnt_inc;

   // A full word is held until the next byte or dv fall says whether it is the tail
   assign w_full_pend = (r_bidx == 4'd0) && (r_cnt != 12'd0);
   assign w_frame_bad = r_bad || (r_cnt < MIN_B) || (r_cnt > MAX_B);
   assign w_tail_vb   = (r_bidx == 4'd0) ? 4'hF : r_bidx - 4'd1;
   assign w_bpos      = {~r_bidx, 3'b000};
   assign w_cnt_inc   = (r_cnt == 12'hFFF) ? r_cnt : r_cnt + 12'd1;
   assign ov_nrp_state = r_state;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state          <= S_IDLE;
         r_word           <= '0;
         r_bidx           <= '0;
         r_widx           <= '0;
         r_cnt            <= '0;
         r_bufid          <= '0;
         r_tsn            <= '0;
         r_first          <= 1'b0;
         r_bad            <= 1'b0;
         r_late           <= 1'b0;
         o_bufid_rd       <= 1'b0;
         ov_pkt_data      <= '0;
         ov_pkt_waddr     <= '0;
         o_pkt_wr         <= 1'b0;
         ov_descriptor    <= '0;
         o_descriptor_wr  <= 1'b0;
         ov_release_bufid <= '0;
         o_release_wr     <= 1'b0;
         o_pkt_cnt_pulse  <= 1'b0;
         o_discard_pulse  <= 1'b0;
      end else begin
         o_bufid_rd      <= 1'b0;
         o_pkt_wr        <= 1'b0;
         o_pkt_cnt_pulse <= 1'b0;
         o_discard_pulse <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (i_gmii_rx_dv) r_state <= S_PRE;
            end
            S_PRE: begin
               if (!i_gmii_rx_dv) begin
                  r_state <= S_IDLE;
               end else if (iv_gmii_rxd == 8'hD5) begin
                  if (i_bufid_empty) begin
                     o_discard_pulse <= 1'b1;
                     r_late          <= 1'b0;
                     r_state         <= S_DROP;
                  end else begin
                     o_bufid_rd <= 1'b1;
                     r_bufid    <= iv_free_bufid;
                     r_cnt      <= '0;
                     r_bidx     <= '0;
                     r_widx     <= '0;
                     r_first    <= 1'b1;
                     r_bad      <= 1'b0;
                     r_state    <= S_RECV;
                  end
               end
            end
            S_RECV: begin
               if (i_gmii_rx_dv) begin
                  if (w_full_pend && !r_bad && !i_gmii_rx_er) begin
                     o_pkt_wr     <= 1'b1;
                     ov_pkt_data  <= {r_first, 1'b0, 4'hF, r_word};
                     ov_pkt_waddr <= {r_bufid, r_widx};
                     r_widx       <= r_widx + 7'd1;
                     r_first      <= 1'b0;
                  end
                  if (r_bidx == 4'd0) r_word <= {iv_gmii_rxd, 120'd0};
                  else r_word[w_bpos +: 8] <= iv_gmii_rxd;
                  r_bidx <= r_bidx + 4'd1;
                  r_cnt  <= w_cnt_inc;
                  if (r_cnt < 12'd6) r_tsn <= {r_tsn[39:0], iv_gmii_rxd};
                  if (i_gmii_rx_er || r_cnt >= MAX_B) r_bad <= 1'b1;
               end else begin
                  r_late <= 1'b0;
                  if (!w_frame_bad) begin
                     o_pkt_wr     <= 1'b1;
                     ov_pkt_data  <= {r_first, 1'b1, w_tail_vb, r_word};
                     ov_pkt_waddr <= {r_bufid, r_widx};
                     r_state      <= S_DESC;
                  end else begin
                     r_state <= S_REL;
                  end
               end
            end
            S_DESC: begin
               r_late <= r_late | i_gmii_rx_dv;
               if (!o_descriptor_wr) begin
                  o_descriptor_wr <= 1'b1;
                  ov_descriptor   <= {r_tsn, r_tsn[47:45], r_bufid};
               end else if (i_descriptor_ack) begin
                  o_descriptor_wr <= 1'b0;
                  o_pkt_cnt_pulse <= 1'b1;
                  r_state <= (r_late | i_gmii_rx_dv) ? S_DROP : S_IDLE;
               end
            end
            S_REL: begin
               r_late <= r_late | i_gmii_rx_dv;
               if (!o_release_wr) begin
                  o_release_wr     <= 1'b1;
                  ov_release_bufid <= r_bufid;
               end else if (i_release_ack) begin
                  o_release_wr    <= 1'b0;
                  o_discard_pulse <= 1'b1;
                  r_state <= (r_late | i_gmii_rx_dv) ? S_DROP : S_IDLE;
               end
            end
            S_DROP: begin
               // A frame overlapping a handshake is counted once it has passed
               if (!i_gmii_rx_dv) begin
                  o_discard_pulse <= r_late;
                  r_late          <= 1'b0;
                  r_state         <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_network_receive_port.sv
// Bench for network_receive_port: random frames checked against
// a byte-array model of PCB words, descriptors and releases.
module tb_network_receive_port;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [7:0]   rxd;
   logic         dv, er;
   logic [8:0]   free_bufid;
   logic         bufid_empty;
   logic         bufid_rd;
   logic [133:0] pkt_data;
   logic [15:0]  pkt_waddr;
   logic         pkt_wr;
   logic [59:0]  desc;
   logic         desc_wr;
   logic         desc_ack = 1'b0;
   logic [8:0]   rel_bufid;
   logic         rel_wr;
   logic         rel_ack = 1'b0;
   logic         pkt_cnt_pulse, discard_pulse;
   logic [2:0]   st;

   int total = 0;
   int bad = 0;

   network_receive_port dut (
      .i_clk(clk), .i_rst(rst),
      .iv_gmii_rxd(rxd), .i_gmii_rx_dv(dv), .i_gmii_rx_er(er),
      .iv_free_bufid(free_bufid), .i_bufid_empty(bufid_empty),
      .o_bufid_rd(bufid_rd),
      .ov_pkt_data(pkt_data), .ov_pkt_waddr(pkt_waddr), .o_pkt_wr(pkt_wr),
      .ov_descriptor(desc), .o_descriptor_wr(desc_wr),
      .i_descriptor_ack(desc_ack),
      .ov_release_bufid(rel_bufid), .o_release_wr(rel_wr),
      .i_release_ack(rel_ack),
      .o_pkt_cnt_pulse(pkt_cnt_pulse), .o_discard_pulse(discard_pulse),
      .ov_nrp_state(st)
   );

   always #5 clk = ~clk;

   logic [7:0]   fb [0:2099];
   logic [149:0] wq [$];
   logic [59:0]  dq [$];
   logic [8:0]   rq [$];
   int cyc = 0;
   int n_rd = 0, n_cnt = 0, n_disc = 0;
   int b_rd, b_cnt, b_disc;
   int t_tail = -1, t_desc = -1, t_dvfall = -1;
   logic desc_prev = 1'b0;
   bit hold_desc = 1'b0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      desc_ack = desc_wr && !hold_desc && !desc_ack;
      rel_ack  = rel_wr && !rel_ack;
   end

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (pkt_wr) begin
            wq.push_back({pkt_waddr, pkt_data});
            if (pkt_data[132]) t_tail = cyc;
         end
         if (desc_wr && !desc_prev) t_desc = cyc;
         if (desc_wr && desc_ack) dq.push_back(desc);
         if (rel_wr && rel_ack) rq.push_back(rel_bufid);
         if (bufid_rd) n_rd++;
         if (pkt_cnt_pulse) n_cnt++;
         if (discard_pulse) n_disc++;
      end
      desc_prev = desc_wr;
   end

   task automatic chk(input string tag, input logic [149:0] obs,
                      input logic [149:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fill_rand(input int n);
      for (int i = 0; i < n; i++) fb[i] = 8'($urandom);
   endtask

   function automatic logic [59:0] mkdesc(input logic [8:0] bid);
      logic [47:0] t;
      t = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]};
      return {t, t[47:45], bid};
   endfunction

   task automatic snap();
      wq.delete();
      dq.delete();
      rq.delete();
      b_rd = n_rd;
      b_cnt = n_cnt;
      b_disc = n_disc;
      t_tail = -1;
      t_desc = -1;
   endtask

   task automatic send_frame(input int n, input logic [8:0] bid,
                             input bit empty, input int erpos);
      free_bufid = bid;
      bufid_empty = empty;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         dv = 1'b1;
         er = 1'b0;
         rxd = (i == 7) ? 8'hD5 : 8'h55;
      end
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         rxd = fb[i];
         er = (i == erpos);
      end
      @(posedge clk);
      #1;
      dv = 1'b0;
      er = 1'b0;
      rxd = 8'h00;
      t_dvfall = cyc;
      repeat (12) @(posedge clk);
   endtask

   task automatic wait_result(input string tag);
      int c = 0;
      while (dq.size() + rq.size() == 0 && c < 300) begin
         @(negedge clk);
         c++;
      end
      chk($sformatf("%s:timeout", tag), c < 300, 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic expect_good(input string tag, input int n,
                              input logic [8:0] bid);
      int k;
      logic [127:0] w;
      logic [3:0] vb;
      wait_result(tag);
      k = (n + 15) / 16;
      chk($sformatf("%s:nwr", tag), wq.size(), k);
      for (int i = 0; i < k && i < wq.size(); i++) begin
         w = '0;
         for (int b = 0; b < 16; b++)
            if (16 * i + b < n) w[127 - 8 * b -: 8] = fb[16 * i + b];
         vb = (i == k - 1) ? 4'(n - 16 * i - 1) : 4'hF;
         chk($sformatf("%s:w%0d", tag, i), wq[i],
             {bid, 7'(i), i == 0, i == k - 1, vb, w});
      end
      chk($sformatf("%s:ndesc", tag), dq.size(), 1);
      chk($sformatf("%s:desc", tag), dq[0], mkdesc(bid));
      chk($sformatf("%s:nrel", tag), rq.size(), 0);
      chk($sformatf("%s:cnt", tag), n_cnt - b_cnt, 1);
      chk($sformatf("%s:disc", tag), n_disc - b_disc, 0);
      chk($sformatf("%s:rd", tag), n_rd - b_rd, 1);
      chk($sformatf("%s:lat_tail", tag), t_tail - t_dvfall, 1);
      chk($sformatf("%s:lat_desc", tag), t_desc - t_tail, 1);
   endtask

   task automatic expect_bad(input string tag, input logic [8:0] bid,
                             input int nwr);
      int tails = 0;
      wait_result(tag);
      foreach (wq[i]) if (wq[i][132]) tails++;
      chk($sformatf("%s:nrel", tag), rq.size(), 1);
      chk($sformatf("%s:relid", tag), rq[0], bid);
      chk($sformatf("%s:ndesc", tag), dq.size(), 0);
      chk($sformatf("%s:tails", tag), tails, 0);
      chk($sformatf("%s:disc", tag), n_disc - b_disc, 1);
      chk($sformatf("%s:cnt", tag), n_cnt - b_cnt, 0);
      if (nwr >= 0) chk($sformatf("%s:nwr", tag), wq.size(), nwr);
   endtask

   initial begin
      int n;
      int n_a;
      logic [8:0] bid;
      logic [59:0] e_a;
      rxd = 8'h00;
      dv = 1'b0;
      er = 1'b0;
      free_bufid = '0;
      bufid_empty = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst:wr", {pkt_wr, bufid_rd, desc_wr, rel_wr}, 0);
      chk("rst:pulse", {pkt_cnt_pulse, discard_pulse}, 0);
      chk("rst:state", st, 0);
      chk("rst:data", {pkt_waddr, pkt_data}, 0);
      chk("rst:desc", {desc, rel_bufid}, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);

      snap();
      fill_rand(64);
      send_frame(64, 9'h005, 1'b0, -1);
      expect_good("f64", 64, 9'h005);
      chk("f64:addr3", wq[3][149:134], 16'h0283);

      snap();
      fill_rand(65);
      fb[0] = 8'hE0; fb[1] = 8'h11; fb[2] = 8'h22;
      fb[3] = 8'h33; fb[4] = 8'h44; fb[5] = 8'h55;
      send_frame(65, 9'h0A3, 1'b0, -1);
      expect_good("f65", 65, 9'h0A3);
      chk("f65:ptype", dq[0][11:9], 3'b111);

      snap();
      fill_rand(100);
      send_frame(100, 9'h010, 1'b0, 29);
      expect_bad("rxer", 9'h010, 1);

      snap();
      fill_rand(2049);
      send_frame(2049, 9'h1F0, 1'b0, -1);
      expect_bad("long", 9'h1F0, 128);

      snap();
      fill_rand(2048);
      send_frame(2048, 9'h0C1, 1'b0, -1);
      expect_good("max", 2048, 9'h0C1);

      snap();
      fill_rand(40);
      send_frame(40, 9'h021, 1'b0, -1);
      expect_bad("runt", 9'h021, -1);

      snap();
      fill_rand(80);
      send_frame(80, 9'h1AA, 1'b1, -1);
      repeat (5) @(negedge clk);
      chk("empty:rd", n_rd - b_rd, 0);
      chk("empty:nwr", wq.size(), 0);
      chk("empty:disc", n_disc - b_disc, 1);
      chk("empty:hs", dq.size() + rq.size(), 0);

      for (int r = 0; r < 5; r++) begin
         snap();
         n = int'($urandom_range(64, 300));
         bid = 9'($urandom);
         fill_rand(n);
         send_frame(n, bid, 1'b0, -1);
         expect_good($sformatf("rnd%0d", r), n, bid);
      end

      snap();
      hold_desc = 1'b1;
      fill_rand(70);
      e_a = mkdesc(9'h033);
      send_frame(70, 9'h033, 1'b0, -1);
      n_a = wq.size();
      fork
         send_frame(64, 9'h044, 1'b0, -1);
         begin
            repeat (50) begin
               @(negedge clk);
               chk("dly:hold", {desc_wr, desc}, {1'b1, e_a});
            end
            hold_desc = 1'b0;
         end
      join
      repeat (5) @(negedge clk);
      chk("dly:nwr_a", n_a, 5);
      chk("dly:nwr", wq.size(), 5);
      chk("dly:ndesc", dq.size(), 1);
      chk("dly:desc", dq[0], e_a);
      chk("dly:cnt", n_cnt - b_cnt, 1);
      chk("dly:disc", n_disc - b_disc, 1);
      chk("dly:rd", n_rd - b_rd, 1);
      chk("dly:state", st, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
